// File: rtl/axis_video_frame_arbiter_if.sv
// Stream bundle for axis_video_frame_arbiter: packed slave sources plus one muxed master.
// slave modport is the arbiter's view; master modport is the sources/sink side.
interface axis_video_frame_arbiter_if #(
  parameter int NUM_INPUTS = 2,
  parameter int DW         = 32
);
  logic [NUM_INPUTS*DW-1:0] s_axis_video_in_tdata;
  logic [NUM_INPUTS-1:0]    s_axis_video_in_tvalid;
  logic [NUM_INPUTS-1:0]    s_axis_video_in_tlast;
  logic [NUM_INPUTS-1:0]    s_axis_video_in_tuser;
  logic [NUM_INPUTS-1:0]    s_axis_video_in_tready;
  logic [DW-1:0]            m_axis_video_out_tdata;
  logic                     m_axis_video_out_tvalid;
  logic                     m_axis_video_out_tlast;
  logic                     m_axis_video_out_tuser;
  logic                     m_axis_video_out_tready;

  modport slave (
    input  s_axis_video_in_tdata, s_axis_video_in_tvalid, s_axis_video_in_tlast,
           s_axis_video_in_tuser, m_axis_video_out_tready,
    output s_axis_video_in_tready, m_axis_video_out_tdata, m_axis_video_out_tvalid,
           m_axis_video_out_tlast, m_axis_video_out_tuser
  );

  modport master (
    output s_axis_video_in_tdata, s_axis_video_in_tvalid, s_axis_video_in_tlast,
           s_axis_video_in_tuser, m_axis_video_out_tready,
    input  s_axis_video_in_tready, m_axis_video_out_tdata, m_axis_video_out_tvalid,
           m_axis_video_out_tlast, m_axis_video_out_tuser
  );
endinterface

// File: rtl/axis_video_frame_arbiter.sv
// Frame-granular round-robin arbiter: N AXI-Stream video sources onto one master.
// Optional AXIS_VIDEO_ARB_SOF_ALIGN_EN drops non-SOF beats of non-granted sources.
module axis_video_frame_arbiter #(
  parameter int NUM_INPUTS     = 2,
  parameter int IMAGE_HEIGHT   = 426,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  localparam int DW = BITS_PER_PIXEL*PIXEL_PER_CLK,
  localparam int GW = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axis_video_frame_arbiter_if.slave    bus,
  output logic [GW-1:0]                grant_idx,
  output logic                         frame_active,
  output logic                         frame_done,
  output logic                         err_early_sof
);
  localparam int LW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [LW-1:0] LAST_LINE = LW'(IMAGE_HEIGHT-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state_q;
  logic [GW-1:0] grant_q, last_grant_q;
  logic [LW-1:0] line_cnt_q;
  logic          first_q, active_q, done_q, err_q;

  logic [NUM_INPUTS-1:0] req;
  logic [GW-1:0]         winner;
  logic                  any_req;
  logic [DW-1:0]         sel_data;
  logic                  sel_valid, sel_last, sel_user;
  logic                  streaming, hs, early;
  logic [LW-1:0]         base_cnt;

  // Reverse scan so the last hit is the first source after last_grant.
  always_comb begin
    int idx;
    idx     = 0;
    req     = bus.s_axis_video_in_tvalid & bus.s_axis_video_in_tuser;
    winner  = '0;
    any_req = 1'b0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_INPUTS;
      if (req[idx]) begin
        winner  = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    streaming = (state_q == STREAM);
    sel_data  = bus.s_axis_video_in_tdata[int'(grant_q)*DW +: DW];
    sel_valid = bus.s_axis_video_in_tvalid[grant_q];
    sel_last  = bus.s_axis_video_in_tlast[grant_q];
    sel_user  = bus.s_axis_video_in_tuser[grant_q];

    bus.m_axis_video_out_tdata  = streaming ? sel_data : '0;
    bus.m_axis_video_out_tvalid = streaming & sel_valid;
    bus.m_axis_video_out_tlast  = streaming & sel_last;
    bus.m_axis_video_out_tuser  = streaming & sel_user;

    bus.s_axis_video_in_tready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (streaming && GW'(i) == grant_q)
        bus.s_axis_video_in_tready[i] = bus.m_axis_video_out_tready;
`ifdef AXIS_VIDEO_ARB_SOF_ALIGN_EN
      else
        bus.s_axis_video_in_tready[i] = bus.s_axis_video_in_tvalid[i] &
                                        ~bus.s_axis_video_in_tuser[i];
`endif
    end

    hs       = streaming & sel_valid & bus.m_axis_video_out_tready;
    // A SOF beyond the first beat restarts the frame on the same grant.
    early    = hs & sel_user & ((line_cnt_q != '0) | ~first_q);
    base_cnt = early ? '0 : line_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_INPUTS-1);
      line_cnt_q   <= '0;
      first_q      <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= early;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= winner;
            line_cnt_q <= '0;
            first_q    <= 1'b1;
            active_q   <= 1'b1;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            first_q <= 1'b0;
            if (sel_last && base_cnt == LAST_LINE) begin
              done_q       <= 1'b1;
              last_grant_q <= grant_q;
              line_cnt_q   <= '0;
              active_q     <= 1'b0;
              state_q      <= IDLE;
            end else if (sel_last) begin
              line_cnt_q <= base_cnt + LW'(1);
            end else begin
              line_cnt_q <= base_cnt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_idx     = grant_q;
  assign frame_active  = active_q;
  assign frame_done    = done_q;
  assign err_early_sof = err_q;
endmodule

// File: tb/tb_axis_video_frame_arbiter.sv
// Directed bench for axis_video_frame_arbiter (NUM_INPUTS=2, IMAGE_HEIGHT=3, 32-bit beats).
module tb_axis_video_frame_arbiter;
  localparam int N  = 2;
  localparam int H  = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:0] grant_idx;
  logic frame_active, frame_done, err_early_sof;

  always #5 clk = ~clk;

  axis_video_frame_arbiter_if #(.NUM_INPUTS(N), .DW(DW)) bus ();

  axis_video_frame_arbiter #(
    .NUM_INPUTS(N), .IMAGE_HEIGHT(H), .PIXEL_PER_CLK(1), .BITS_PER_PIXEL(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_idx(grant_idx), .frame_active(frame_active),
    .frame_done(frame_done), .err_early_sof(err_early_sof)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  vld, usr, lst;
    logic [31:0] d0;
    logic        mrdy;
    logic        e_mvld, e_musr, e_mlst;
    logic [31:0] e_mdat;
    logic [1:0]  e_srdy;
    logic        e_act, e_done;
  } vec_t;

  vec_t tv[$];

  // Source model: each source replays frames of len beats, W beats per line.
  int  W;
  bit  en[N];
  int  beat[N], frm[N], len[N], nfrm[N], sof2[N];
  int  n_done, n_err, n_mlast, mlast_at_err, mlast_at_done;
  int  gq[$];
  logic prev_act;
  logic [0:0] prev_g;

  function automatic logic [31:0] bdata(input int i);
    return {8'(i), 8'(frm[i]), 16'(beat[i])};
  endfunction

  function automatic logic exp_other(input int j);
`ifdef AXIS_VIDEO_ARB_SOF_ALIGN_EN
    return bus.s_axis_video_in_tvalid[j] & ~bus.s_axis_video_in_tuser[j];
`else
    return (j < 0);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; beat[i] = 0; frm[i] = 0; len[i] = 0; nfrm[i] = 0; sof2[i] = -1;
    end
    n_done = 0; n_err = 0; n_mlast = 0; mlast_at_err = 0; mlast_at_done = 0;
    gq.delete();
    prev_act = 1'b0; prev_g = '0;
  endtask

  task automatic drive_model();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_video_in_tvalid[i] = en[i];
      bus.s_axis_video_in_tuser[i]  = en[i] && (beat[i] == 0 || beat[i] == sof2[i]);
      bus.s_axis_video_in_tlast[i]  = en[i] && (beat[i] % W == W-1);
      bus.s_axis_video_in_tdata[i*DW +: DW] = bdata(i);
    end
  endtask

  task automatic cycle(input logic mrdy);
    int g;
    logic [1:0] hs_src;
    @(negedge clk);
    drive_model();
    bus.m_axis_video_out_tready = mrdy;
    #1;
    g = int'(grant_idx);
    if (frame_active) begin
      chk("m_tvalid", bus.m_axis_video_out_tvalid, bus.s_axis_video_in_tvalid[g]);
      chk("m_tdata", bus.m_axis_video_out_tdata, bus.s_axis_video_in_tdata[g*DW +: DW]);
      chk("srdy_granted", bus.s_axis_video_in_tready[g], mrdy);
      for (int j = 0; j < N; j++)
        if (j != g) chk("srdy_other", bus.s_axis_video_in_tready[j], exp_other(j));
      if (bus.m_axis_video_out_tvalid && mrdy) begin
        chk("beat_src", bus.m_axis_video_out_tdata[31:24], g);
        if (bus.m_axis_video_out_tlast) n_mlast++;
      end
      if (prev_act) chk("grant_hold", grant_idx, prev_g);
      else gq.push_back(g);
    end else begin
      chk("idle_mvalid", bus.m_axis_video_out_tvalid, 0);
      for (int j = 0; j < N; j++)
        chk("idle_srdy", bus.s_axis_video_in_tready[j], exp_other(j));
    end
    if (frame_done) begin n_done++; mlast_at_done = n_mlast; end
    if (err_early_sof) begin n_err++; mlast_at_err = n_mlast; end
    hs_src = bus.s_axis_video_in_tvalid & bus.s_axis_video_in_tready;
    for (int i = 0; i < N; i++) begin
      if (hs_src[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) begin
          beat[i] = 0; frm[i]++;
          if (frm[i] == nfrm[i]) en[i] = 0;
        end
      end
    end
    prev_act = frame_active;
    prev_g   = grant_idx;
  endtask

  function automatic bit any_en();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= en[i];
    return r;
  endfunction

  task automatic run(input string nm, input bit toggle);
    int c = 0;
    while ((any_en() || frame_active) && c < 2000) begin
      cycle(toggle ? logic'(c % 2 == 0) : 1'b1);
      c++;
    end
    chk({nm, ".no_timeout"}, (c < 2000), 1);
    cycle(1'b1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".m_tvalid"}, bus.m_axis_video_out_tvalid, 0);
    chk({nm, ".m_tdata"}, bus.m_axis_video_out_tdata, 0);
    chk({nm, ".m_tuser"}, bus.m_axis_video_out_tuser, 0);
    chk({nm, ".m_tlast"}, bus.m_axis_video_out_tlast, 0);
    chk({nm, ".grant"}, grant_idx, 0);
    chk({nm, ".active"}, frame_active, 0);
    chk({nm, ".done"}, frame_done, 0);
    chk({nm, ".err"}, err_early_sof, 0);
    for (int j = 0; j < N; j++) chk({nm, ".srdy"}, bus.s_axis_video_in_tready[j], exp_other(j));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    W = 4;
    model_clear();
    bus.s_axis_video_in_tdata  = '0;
    bus.s_axis_video_in_tvalid = '0;
    bus.s_axis_video_in_tlast  = '0;
    bus.s_axis_video_in_tuser  = '0;
    bus.m_axis_video_out_tready = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-source 4x3 frame from source 0, one vector per cycle.
    v = '{vld:2'b00, usr:2'b00, lst:2'b00, d0:32'h0, mrdy:1'b1, e_mvld:1'b0, e_musr:1'b0,
          e_mlst:1'b0, e_mdat:32'h0, e_srdy:2'b00, e_act:1'b0, e_done:1'b0};
    tv.push_back(v);
    v.vld = 2'b01; v.usr = 2'b01; v.d0 = 32'h100;
    tv.push_back(v);
    for (int b = 0; b < 12; b++) begin
      v.vld = 2'b01; v.usr = {1'b0, b == 0}; v.lst = {1'b0, b % 4 == 3};
      v.d0 = 32'h100 + 32'(b);
      v.e_mvld = 1'b1; v.e_musr = (b == 0); v.e_mlst = (b % 4 == 3);
      v.e_mdat = 32'h100 + 32'(b); v.e_srdy = 2'b01; v.e_act = 1'b1; v.e_done = 1'b0;
      tv.push_back(v);
    end
    v = '{vld:2'b00, usr:2'b00, lst:2'b00, d0:32'h0, mrdy:1'b1, e_mvld:1'b0, e_musr:1'b0,
          e_mlst:1'b0, e_mdat:32'h0, e_srdy:2'b00, e_act:1'b0, e_done:1'b1};
    tv.push_back(v);
    v.e_done = 1'b0;
    tv.push_back(v);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      bus.s_axis_video_in_tvalid = tv[k].vld;
      bus.s_axis_video_in_tuser  = tv[k].usr;
      bus.s_axis_video_in_tlast  = tv[k].lst;
      bus.s_axis_video_in_tdata  = {32'hDEAD_BEEF, tv[k].d0};
      bus.m_axis_video_out_tready = tv[k].mrdy;
      #1;
      chk($sformatf("v%0d.mvld", k), bus.m_axis_video_out_tvalid, tv[k].e_mvld);
      chk($sformatf("v%0d.musr", k), bus.m_axis_video_out_tuser, tv[k].e_musr);
      chk($sformatf("v%0d.mlst", k), bus.m_axis_video_out_tlast, tv[k].e_mlst);
      chk($sformatf("v%0d.mdat", k), bus.m_axis_video_out_tdata, tv[k].e_mdat);
      chk($sformatf("v%0d.srdy", k), bus.s_axis_video_in_tready, tv[k].e_srdy);
      chk($sformatf("v%0d.grant", k), grant_idx, 0);
      chk($sformatf("v%0d.act", k), frame_active, tv[k].e_act);
      chk($sformatf("v%0d.done", k), frame_done, tv[k].e_done);
      chk($sformatf("v%0d.err", k), err_early_sof, 0);
    end

    // Round-robin: both sources offer two 1-beat-per-line frames each.
    apply_reset();
    model_clear(); W = 1;
    for (int i = 0; i < N; i++) begin en[i] = 1; len[i] = 3; nfrm[i] = 2; end
    run("rr", 1'b0);
    chk("rr.frames", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("rr.g0", gq[0], 0); chk("rr.g1", gq[1], 1);
      chk("rr.g2", gq[2], 0); chk("rr.g3", gq[3], 1);
    end
    chk("rr.done", n_done, 4);

    // Backpressure: m_tready toggles every cycle during a 4x3 frame.
    model_clear(); W = 4;
    en[0] = 1; len[0] = 12; nfrm[0] = 1;
    run("bp", 1'b1);
    chk("bp.done", n_done, 1);
    chk("bp.lines", n_mlast, 3);
    chk("bp.err", n_err, 0);

    // Early SOF on the first beat of line 2: frame restarts, three more lines.
    model_clear(); W = 4;
    en[0] = 1; len[0] = 16; nfrm[0] = 1; sof2[0] = 4;
    run("esof", 1'b0);
    chk("esof.err", n_err, 1);
    chk("esof.done", n_done, 1);
    chk("esof.lines_before_err", mlast_at_err, 1);
    chk("esof.lines_after_err", mlast_at_done - mlast_at_err, 3);

    // Asynchronous reset in line 2 of a source-1 frame.
    model_clear(); W = 4;
    en[1] = 1; len[1] = 12; nfrm[1] = 1;
    for (int c = 0; c < 40 && beat[1] < 6; c++) cycle(1'b1);
    chk("arst.reached_line2", beat[1], 6);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear(); W = 1;
    for (int i = 0; i < N; i++) begin en[i] = 1; len[i] = 3; nfrm[i] = 1; end
    run("arst", 1'b0);
    chk("arst.frames", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("arst.first", gq[0], 0);
      chk("arst.second", gq[1], 1);
    end

`ifdef AXIS_VIDEO_ARB_SOF_ALIGN_EN
    // Source 1 starts mid-frame; its non-SOF beats are dropped while source 0 streams.
    model_clear(); W = 4;
    en[0] = 1; len[0] = 12; nfrm[0] = 1;
    en[1] = 1; len[1] = 12; nfrm[1] = 2; beat[1] = 5;
    run("align", 1'b0);
    chk("align.frames", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("align.first", gq[0], 0);
      chk("align.second", gq[1], 1);
    end
    chk("align.done", n_done, 2);
    chk("align.lines", n_mlast, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
